mac_sched: RTL and testbench

MAC_SCHED -- requirements
Module: mac_sched

---
 rtl/mac_sched_pkg.sv | 20 ++
 rtl/mac_sched_rr.sv | 33 +++
 rtl/mac_sched.sv | 181 ++++++++++++++++++
 tb/tb_mac_sched.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_sched_pkg.sv
// Shared types and constants for the MAC request scheduler.
package mac_sched_pkg;

  localparam int DATA_W      = 16;
  localparam int ACC_W       = 32;
  localparam int NREQ_DEF    = 4;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_sched_rr.sv
// Round-robin arbiter: picks the first set request starting at ptr,
// wrapping modulo NREQ, and returns it one-hot.
module rr_arbiter
  import mac_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int PTR_W = ptr_width(NREQ_DEF)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  winner,
  output logic             any_req
);

  logic [PTR_W-1:0] cand;

  // Scan from the farthest position back toward ptr so the candidate
  // closest to ptr is the one left standing.
  always_comb begin
    winner = '0;
    cand   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = PTR_W'((int'(ptr) + i) % NREQ);
      if (req[cand]) begin
        winner       = '0;
        winner[cand] = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/mac_sched.sv
// Scheduler that lets NREQ requesters share one external MAC, one
// operation at a time, with round-robin fairness and a WAIT timeout.
module mac_sched
  import mac_sched_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   a_in,
  input  logic [NREQ*DATA_W-1:0]   b_in,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rsp_valid,
  output logic signed [ACC_W-1:0]  rsp_y,
  output logic                     rsp_err,
  output logic                     mac_valid,
  output logic signed [DATA_W-1:0] mac_a,
  output logic signed [DATA_W-1:0] mac_b,
  input  logic signed [ACC_W-1:0]  mac_y,
  input  logic                     mac_done
);

  localparam int PTR_W = ptr_width(NREQ);
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t                   state_q, state_n;
  logic [PTR_W-1:0]         idx_q, idx_n;
  logic [PTR_W-1:0]         ptr_q, ptr_n;
  logic [TMR_W-1:0]         timer_q, timer_n;
  logic signed [DATA_W-1:0] a_q, a_n;
  logic signed [DATA_W-1:0] b_q, b_n;
  logic signed [ACC_W-1:0]  y_q, y_n;
  logic                     err_q, err_n;
  logic [NREQ-1:0]          block_q, block_n;

  logic [NREQ-1:0]          arb_req;
  logic [NREQ-1:0]          winner;
  logic                     any_req;
  logic [PTR_W-1:0]         win_idx;
  logic signed [DATA_W-1:0] win_a;
  logic signed [DATA_W-1:0] win_b;
  logic [NREQ-1:0]          idx_onehot;

  assign arb_req = req & ~block_q;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .req     (arb_req),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  // Turn the one-hot winner into an index and pick up its operands.
  always_comb begin
    win_idx = '0;
    win_a   = '0;
    win_b   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner[i]) begin
        win_idx = PTR_W'(i);
        win_a   = a_in[i*DATA_W +: DATA_W];
        win_b   = b_in[i*DATA_W +: DATA_W];
      end
    end
  end

  // Decode the latched requester index for the grant and response buses.
  always_comb begin
    idx_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (idx_q == PTR_W'(i)) begin
        idx_onehot[i] = 1'b1;
      end
    end
  end

  // Next-state and output decode; a just-served requester is blocked for
  // the single IDLE cycle after its response so it cannot be re-picked.
  always_comb begin
    state_n   = state_q;
    idx_n     = idx_q;
    ptr_n     = ptr_q;
    timer_n   = timer_q;
    a_n       = a_q;
    b_n       = b_q;
    y_n       = y_q;
    err_n     = err_q;
    block_n   = '0;
    gnt       = '0;
    rsp_valid = '0;
    rsp_y     = '0;
    rsp_err   = 1'b0;
    mac_valid = 1'b0;
    mac_a     = '0;
    mac_b     = '0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          idx_n   = win_idx;
          a_n     = win_a;
          b_n     = win_b;
          state_n = ISSUE;
        end
      end

      ISSUE: begin
        gnt       = idx_onehot;
        mac_valid = 1'b1;
        mac_a     = a_q;
        mac_b     = b_q;
        timer_n   = '0;
        state_n   = WAIT;
      end

      WAIT: begin
        gnt   = idx_onehot;
        mac_a = a_q;
        mac_b = b_q;
        if (mac_done) begin
          y_n     = mac_y;
          err_n   = 1'b0;
          state_n = RESP;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          y_n     = '0;
          err_n   = 1'b1;
          state_n = RESP;
        end else begin
          timer_n = timer_q + TMR_W'(1);
        end
      end

      RESP: begin
        gnt       = idx_onehot;
        mac_a     = a_q;
        mac_b     = b_q;
        rsp_valid = idx_onehot;
        rsp_y     = y_q;
        rsp_err   = err_q;
        ptr_n     = (idx_q == PTR_W'(NREQ - 1)) ? '0 : idx_q + PTR_W'(1);
        block_n   = idx_onehot;
        state_n   = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      timer_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      block_q <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
      ptr_q   <= ptr_n;
      timer_q <= timer_n;
      a_q     <= a_n;
      b_q     <= b_n;
      y_q     <= y_n;
      err_q   <= err_n;
      block_q <= block_n;
    end
  end

endmodule

// File: tb/tb_mac_sched.sv
// Scoreboard bench for mac_sched with a behavioural MAC and a
// transaction-level round-robin reference model.
module tb_mac_sched;
  import mac_sched_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [N-1:0]            req;
  logic [N*16-1:0]         a_in;
  logic [N*16-1:0]         b_in;
  logic [N-1:0]            gnt;
  logic [N-1:0]            rsp_valid;
  logic signed [31:0]      rsp_y;
  logic                    rsp_err;
  logic                    mac_valid;
  logic signed [15:0]      mac_a;
  logic signed [15:0]      mac_b;
  logic signed [31:0]      mac_y;
  logic                    mac_done;

  logic signed [15:0]      op_a [N];
  logic signed [15:0]      op_b [N];

  typedef struct {
    int                 idx;
    logic signed [15:0] a;
    logic signed [15:0] b;
  } iss_t;

  typedef struct {
    int                 idx;
    logic signed [31:0] y;
    logic               err;
  } rsp_t;

  iss_t exp_iss[$];
  rsp_t exp_rsp[$];

  int checks    = 0;
  int failures  = 0;
  int model_ptr = 0;
  int mac_delay = 3;
  int mac_cnt   = -1;
  int rsp_seen  = 0;
  logic signed [31:0] pend_y;
  logic prev_mv = 1'b0;

  for (genvar g = 0; g < N; g++) begin : g_ops
    assign a_in[g*16 +: 16] = op_a[g];
    assign b_in[g*16 +: 16] = op_b[g];
  end

  mac_sched #(.NREQ(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_y     (rsp_y),
    .rsp_err   (rsp_err),
    .mac_valid (mac_valid),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_y     (mac_y),
    .mac_done  (mac_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_gnt"}, gnt, 0);
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
    checkOutput({tag, "_rsp_y"}, rsp_y, 0);
    checkOutput({tag, "_rsp_err"}, rsp_err, 0);
    checkOutput({tag, "_mac_valid"}, mac_valid, 0);
    checkOutput({tag, "_mac_a"}, mac_a, 0);
    checkOutput({tag, "_mac_b"}, mac_b, 0);
  endtask

  // Behavioural MAC: done pulses mac_delay cycles after valid, y = A*B;
  // a negative delay means it never answers. It ignores the scheduler reset.
  initial begin
    mac_done = 1'b0;
    mac_y    = '0;
    forever begin
      @(posedge clk);
      #1;
      mac_done = 1'b0;
      mac_y    = '0;
      if (mac_cnt > 0) begin
        mac_cnt--;
        if (mac_cnt == 0) begin
          mac_done = 1'b1;
          mac_y    = pend_y;
          mac_cnt  = -1;
        end
      end
      if (mac_valid) begin
        pend_y  = 32'(int'(mac_a) * int'(mac_b));
        mac_cnt = mac_delay;
      end
    end
  end

  // Monitor: compare every issue and every response against the queues.
  always @(negedge clk) begin : monitor
    iss_t e;
    rsp_t r;
    if (!reset) begin
      if (mac_valid) begin
        checkOutput("mac_valid_single_cycle", prev_mv, 0);
        if (exp_iss.size() == 0) begin
          checkOutput("unexpected_issue", mac_valid, 0);
        end else begin
          e = exp_iss.pop_front();
          checkOutput("issue_gnt", gnt, 1 << e.idx);
          checkOutput("issue_mac_a", mac_a, e.a);
          checkOutput("issue_mac_b", mac_b, e.b);
        end
      end
      if (rsp_valid != 0) begin
        rsp_seen++;
        if (exp_rsp.size() == 0) begin
          checkOutput("unexpected_rsp", rsp_valid, 0);
        end else begin
          r = exp_rsp.pop_front();
          checkOutput("rsp_valid", rsp_valid, 1 << r.idx);
          checkOutput("rsp_gnt", gnt, 1 << r.idx);
          checkOutput("rsp_y", rsp_y, r.y);
          checkOutput("rsp_err", rsp_err, r.err);
        end
      end
    end
    prev_mv = mac_valid;
  end

  // Raise the requesters in mask, predict the service order with the
  // round-robin model, and wait until nserve responses have arrived.
  task automatic applyStimulus(input logic [N-1:0] mask, input int delay, input int nserve, input bit sticky);
    logic [N-1:0] pend;
    int w;
    int cand;
    int served;
    int budget;
    iss_t ei;
    rsp_t er;
    @(negedge clk);
    checkOutput("idle_gnt", gnt, 0);
    checkOutput("idle_mac_a", mac_a, 0);
    checkOutput("idle_mac_b", mac_b, 0);
    mac_delay = delay;
    pend = mask;
    for (int k = 0; k < nserve; k++) begin
      w = -1;
      for (int j = 0; j < N; j++) begin
        cand = (model_ptr + j) % N;
        if (w < 0 && ((pend >> cand) & 1) != 0) w = cand;
      end
      ei.idx = w;
      ei.a   = op_a[w];
      ei.b   = op_b[w];
      exp_iss.push_back(ei);
      er.idx = w;
      if (delay >= 1 && delay <= TO) begin
        er.y   = 32'(int'(op_a[w]) * int'(op_b[w]));
        er.err = 1'b0;
      end else begin
        er.y   = 0;
        er.err = 1'b1;
      end
      exp_rsp.push_back(er);
      if (!sticky) pend = pend & ~(N'(1) << w);
      model_ptr = (w + 1) % N;
    end
    req    = mask;
    served = 0;
    budget = nserve * (TO + 8) + 20;
    while (served < nserve && budget > 0) begin
      @(negedge clk);
      budget--;
      if (rsp_valid != 0) begin
        served++;
        if (!sticky) req = req & ~rsp_valid;
      end
    end
    req = '0;
    if (served < nserve) begin
      checkOutput("batch_served", served, nserve);
      exp_iss.delete();
      exp_rsp.delete();
    end
  endtask

  // Abandon an operation with reset while in WAIT; the MAC's late done
  // must not produce any response.
  task automatic resetMidOp();
    iss_t ei;
    int budget;
    int seen_before;
    @(negedge clk);
    op_a[1] = 16'sd77;
    op_b[1] = 16'sd9;
    mac_delay = 3;
    ei.idx = 1;
    ei.a   = op_a[1];
    ei.b   = op_b[1];
    exp_iss.push_back(ei);
    req = 4'b0010;
    budget = 10;
    while (!mac_valid && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("reset_test_issue", mac_valid, 1);
    @(negedge clk);
    reset = 1'b1;
    req   = '0;
    @(posedge clk);
    #1;
    checkAllZero("midop_reset");
    @(negedge clk);
    reset = 1'b0;
    exp_iss.delete();
    exp_rsp.delete();
    model_ptr   = 0;
    seen_before = rsp_seen;
    repeat (8) @(negedge clk);
    checkOutput("reset_no_rsp", rsp_seen - seen_before, 0);
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    reset = 1'b0;

    op_a[0] = 16'sd5;  op_b[0] = 16'sd6;
    op_a[2] = -16'sd7; op_b[2] = 16'sd8;
    applyStimulus(4'b0101, 3, 2, 1'b0);

    op_a[1] = 16'sd11; op_b[1] = 16'sd12;
    op_a[3] = 16'sd13; op_b[3] = -16'sd14;
    applyStimulus(4'b1010, 3, 2, 1'b0);

    op_a[0] = 16'sd30; op_b[0] = 16'sd40;
    applyStimulus(4'b0001, 3, 1, 1'b0);

    op_a[1] = -16'sd111; op_b[1] = -16'sd2;
    applyStimulus(4'b0010, 3, 1, 1'b0);
    op_a[1] = 16'sd40; op_b[1] = -16'sd50;
    applyStimulus(4'b0010, 3, 1, 1'b0);

    op_a[2] = 16'sd100; op_b[2] = 16'sd3;
    applyStimulus(4'b0100, -1, 1, 1'b0);
    op_a[3] = -16'sd9; op_b[3] = 16'sd9;
    applyStimulus(4'b1000, 16, 1, 1'b0);
    applyStimulus(4'b1000, 17, 1, 1'b0);

    for (int it = 0; it < 40; it++) begin
      logic [N-1:0] m;
      int d;
      int sel;
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        op_a[i] = 16'($urandom);
        op_b[i] = 16'($urandom);
      end
      sel = $urandom_range(0, 9);
      case (sel)
        7:       d = 15;
        8:       d = 16;
        9:       d = -1;
        default: d = sel + 1;
      endcase
      applyStimulus(m, d, $countones(m), 1'b0);
    end

    resetMidOp();

    for (int i = 0; i < N; i++) begin
      op_a[i] = 16'(i * 3 + 1);
      op_b[i] = -16'(i + 2);
    end
    applyStimulus(4'b1111, 3, 5, 1'b1);

    repeat (4) @(negedge clk);
    checkOutput("leftover_rsp", exp_rsp.size(), 0);
    checkOutput("leftover_issue", exp_iss.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
